// File: rtl/nrisc_pkg.sv
// Shared nrisc definitions: bus widths, arbiter state encoding and requester ids.
package nrisc_pkg;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int STREAK_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    DONE   = 3'd3,
    HALTED = 3'd4
  } arbState_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } reqId_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data requesters, with a data-streak
// counter that lets a waiting fetch through after a bounded run of data grants.
module mem_arb_prio #(
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic ifReq_i,
  input  logic dReq_i,
  output logic ifGnt_o,
  output logic dGnt_o
);
  import nrisc_pkg::*;

  localparam logic [STREAK_W-1:0] MaxStreak = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                fetchForced;

  // Data wins by default; a waiting fetch wins once the data streak is exhausted.
  always_comb begin
    ifGnt_o     = 1'b0;
    dGnt_o      = 1'b0;
    fetchForced = ifReq_i && (streak_q == MaxStreak);
    if (enable_i) begin
      if (dReq_i && !fetchForced) begin
        dGnt_o = 1'b1;
      end else if (ifReq_i) begin
        ifGnt_o = 1'b1;
      end
    end
  end

  // Count data grants that made a fetch wait; any fetch grant or uncontested data grant clears it.
  always_comb begin
    streak_d = streak_q;
    if (ifGnt_o) begin
      streak_d = '0;
    end else if (dGnt_o) begin
      if (!ifReq_i) begin
        streak_d = '0;
      end else if (streak_q != MaxStreak) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  // Streak register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for nrisc: sequences fetch and load/store
// accesses through the shared memory and freezes it cleanly on halt.
module mem_arbiter #(
  parameter int ADDR_W          = nrisc_pkg::ADDR_W,
  parameter int DATA_W          = nrisc_pkg::DATA_W,
  parameter int READ_LAT        = 1,
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic              c,
  input  logic              reset,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted
);
  import nrisc_pkg::*;

  localparam logic [2:0] LatLast = 3'(READ_LAT - 1);

  arbState_t         state_q;
  reqId_t            winner_q;
  logic              haltPending_q;
  logic [2:0]        latCnt_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic              memRead_q;
  logic              memWrite_q;
  logic [DATA_W-1:0] memWdata_q;
  logic [DATA_W-1:0] ifRdata_q;
  logic [DATA_W-1:0] dRdata_q;
  logic              ifValid_q;
  logic              dValid_q;
  logic              halted_q;

  logic              arbEnable;
  logic              ifGntW;
  logic              dGntW;

  assign arbEnable = (state_q == IDLE) && !halt && !haltPending_q;

  mem_arb_prio #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) uPrio (
    .clk_i   (c),
    .reset_i (reset),
    .enable_i(arbEnable),
    .ifReq_i (if_req),
    .dReq_i  (d_req),
    .ifGnt_o (ifGntW),
    .dGnt_o  (dGntW)
  );

  assign if_gnt    = ifGntW;
  assign d_gnt     = dGntW;
  assign if_rdata  = ifRdata_q;
  assign if_valid  = ifValid_q;
  assign d_rdata   = dRdata_q;
  assign d_valid   = dValid_q;
  assign mem_addr  = memAddr_q;
  assign mem_read  = memRead_q;
  assign mem_write = memWrite_q;
  assign mem_wdata = memWdata_q;
  assign halted    = halted_q;

  // Access sequencer: latch the granted request, drive the strobes, return data, honour halt.
  always_ff @(posedge c) begin
    if (reset) begin
      state_q       <= IDLE;
      winner_q      <= REQ_IF;
      haltPending_q <= 1'b0;
      latCnt_q      <= '0;
      memAddr_q     <= '0;
      memRead_q     <= 1'b0;
      memWrite_q    <= 1'b0;
      memWdata_q    <= '0;
      ifRdata_q     <= '0;
      dRdata_q      <= '0;
      ifValid_q     <= 1'b0;
      dValid_q      <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      ifValid_q <= 1'b0;
      dValid_q  <= 1'b0;
      if (halt) begin
        haltPending_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (halt || haltPending_q) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (dGntW) begin
            winner_q  <= REQ_D;
            memAddr_q <= d_addr;
            if (d_we) begin
              memWrite_q <= 1'b1;
              memWdata_q <= d_wdata;
              state_q    <= WR;
            end else begin
              memRead_q <= 1'b1;
              latCnt_q  <= LatLast;
              state_q   <= RD;
            end
          end else if (ifGntW) begin
            winner_q  <= REQ_IF;
            memAddr_q <= if_addr;
            memRead_q <= 1'b1;
            latCnt_q  <= LatLast;
            state_q   <= RD;
          end
        end
        RD: begin
          if (latCnt_q == 3'd0) begin
            memRead_q <= 1'b0;
            memAddr_q <= '0;
            if (winner_q == REQ_D) begin
              dRdata_q <= mem_rdata;
              dValid_q <= 1'b1;
            end else begin
              ifRdata_q <= mem_rdata;
              ifValid_q <= 1'b1;
            end
            state_q <= DONE;
          end else begin
            latCnt_q <= latCnt_q - 3'd1;
          end
        end
        WR: begin
          memWrite_q <= 1'b0;
          memAddr_q  <= '0;
          memWdata_q <= '0;
          dValid_q   <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (haltPending_q || halt) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        HALTED: begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances with READ_LAT 1, 2 and 3
// share the requester stimulus; each phase checks the instance it targets.
module tb_mem_arbiter;

  logic       c;
  logic       reset;
  logic       halt;
  logic       ifReq;
  logic [7:0] ifAddr;
  logic       dReq;
  logic       dWe;
  logic [7:0] dAddr;
  logic [7:0] dWdata;

  logic       ifGnt    [3];
  logic       ifValid  [3];
  logic       dGnt     [3];
  logic       dValid   [3];
  logic       memRead  [3];
  logic       memWrite [3];
  logic       halted   [3];
  logic [7:0] ifRdata  [3];
  logic [7:0] dRdata   [3];
  logic [7:0] memAddr  [3];
  logic [7:0] memWdata [3];
  logic [7:0] memRdata [3];

  logic [7:0] mem [256];

  int checks;
  int failures;

  initial c = 1'b0;
  always #5 c = ~c;

  for (genvar g = 0; g < 3; g++) begin : gInst
    mem_arbiter #(
      .ADDR_W(8),
      .DATA_W(8),
      .READ_LAT(g + 1),
      .MAX_DATA_STREAK(3)
    ) dut (
      .c        (c),
      .reset    (reset),
      .halt     (halt),
      .if_req   (ifReq),
      .if_addr  (ifAddr),
      .if_gnt   (ifGnt[g]),
      .if_rdata (ifRdata[g]),
      .if_valid (ifValid[g]),
      .d_req    (dReq),
      .d_we     (dWe),
      .d_addr   (dAddr),
      .d_wdata  (dWdata),
      .d_gnt    (dGnt[g]),
      .d_rdata  (dRdata[g]),
      .d_valid  (dValid[g]),
      .mem_addr (memAddr[g]),
      .mem_read (memRead[g]),
      .mem_write(memWrite[g]),
      .mem_wdata(memWdata[g]),
      .mem_rdata(memRdata[g]),
      .halted   (halted[g])
    );
    assign memRdata[g] = mem[memAddr[g]];
  end

  task automatic applyStimulus(input logic iReq, input logic [7:0] iAddr,
                               input logic rq, input logic we,
                               input logic [7:0] a, input logic [7:0] wd);
    ifReq  = iReq;
    ifAddr = iAddr;
    dReq   = rq;
    dWe    = we;
    dAddr  = a;
    dWdata = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic resetAll();
    reset = 1'b1;
    repeat (2) @(negedge c);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic expD;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0] = 8'h3C;
    mem[1] = 8'hC7;
    mem[5] = 8'hA3;
    mem[7] = 8'h11;

    reset = 1'b1;
    halt  = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge c);
    #1;
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("rst%0d_mem_read", g), memRead[g], 8'd0);
      checkOutput($sformatf("rst%0d_mem_write", g), memWrite[g], 8'd0);
      checkOutput($sformatf("rst%0d_mem_addr", g), memAddr[g], 8'd0);
      checkOutput($sformatf("rst%0d_mem_wdata", g), memWdata[g], 8'd0);
      checkOutput($sformatf("rst%0d_if_valid", g), ifValid[g], 8'd0);
      checkOutput($sformatf("rst%0d_d_valid", g), dValid[g], 8'd0);
      checkOutput($sformatf("rst%0d_if_rdata", g), ifRdata[g], 8'd0);
      checkOutput($sformatf("rst%0d_d_rdata", g), dRdata[g], 8'd0);
      checkOutput($sformatf("rst%0d_halted", g), halted[g], 8'd0);
      checkOutput($sformatf("rst%0d_if_gnt", g), ifGnt[g], 8'd0);
      checkOutput($sformatf("rst%0d_d_gnt", g), dGnt[g], 8'd0);
    end
    reset = 1'b0;

    // Fetch from addr 5 on the READ_LAT=1 instance.
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkOutput("fetch_if_gnt", ifGnt[0], 8'd1);
    checkOutput("fetch_d_gnt", dGnt[0], 8'd0);
    @(negedge c);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkOutput("fetch_mem_read", memRead[0], 8'd1);
    checkOutput("fetch_mem_addr", memAddr[0], 8'h05);
    checkOutput("fetch_valid_early", ifValid[0], 8'd0);
    @(negedge c);
    #1;
    checkOutput("fetch_if_valid", ifValid[0], 8'd1);
    checkOutput("fetch_if_rdata", ifRdata[0], 8'hA3);
    checkOutput("fetch_read_off", memRead[0], 8'd0);
    checkOutput("fetch_addr_zero", memAddr[0], 8'd0);
    @(negedge c);
    #1;
    checkOutput("fetch_valid_pulse", ifValid[0], 8'd0);
    checkOutput("fetch_rdata_held", ifRdata[0], 8'hA3);

    // Store 0x5C to 0x10.
    @(negedge c);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 8'h5C);
    #1;
    checkOutput("store_d_gnt", dGnt[0], 8'd1);
    checkOutput("store_if_gnt", ifGnt[0], 8'd0);
    @(negedge c);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkOutput("store_mem_write", memWrite[0], 8'd1);
    checkOutput("store_mem_addr", memAddr[0], 8'h10);
    checkOutput("store_mem_wdata", memWdata[0], 8'h5C);
    checkOutput("store_no_read", memRead[0], 8'd0);
    @(negedge c);
    #1;
    checkOutput("store_d_valid", dValid[0], 8'd1);
    checkOutput("store_write_off", memWrite[0], 8'd0);
    checkOutput("store_no_read2", memRead[0], 8'd0);
    @(negedge c);
    #1;
    checkOutput("store_valid_pulse", dValid[0], 8'd0);

    // Contention: both requesters held, expect D,D,D,IF twice.
    for (int k = 0; k < 8; k++) begin
      @(negedge c);
      if (k == 0) applyStimulus(1'b1, 8'h20, 1'b1, 1'b0, 8'h07, 8'h00);
      #1;
      expD = ((k % 4) != 3);
      checkOutput($sformatf("cont%0d_d_gnt", k), dGnt[0], {7'd0, expD});
      checkOutput($sformatf("cont%0d_if_gnt", k), ifGnt[0], {7'd0, !expD});
      repeat (2) begin
        @(negedge c);
        #1;
        checkOutput($sformatf("cont%0d_busy_gnt", k), {7'd0, dGnt[0] | ifGnt[0]}, 8'd0);
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

    // Halt during the RD cycle of a load from addr 7.
    @(negedge c);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h07, 8'h00);
    #1;
    checkOutput("halt_d_gnt", dGnt[0], 8'd1);
    @(negedge c);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    halt = 1'b1;
    #1;
    checkOutput("halt_mem_read", memRead[0], 8'd1);
    checkOutput("halt_mem_addr", memAddr[0], 8'h07);
    @(negedge c);
    halt = 1'b0;
    #1;
    checkOutput("halt_d_valid", dValid[0], 8'd1);
    checkOutput("halt_d_rdata", dRdata[0], 8'h11);
    checkOutput("halt_not_yet", halted[0], 8'd0);
    @(negedge c);
    #1;
    checkOutput("halt_halted", halted[0], 8'd1);
    checkOutput("halt_valid_off", dValid[0], 8'd0);
    @(negedge c);
    applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, 8'h04, 8'h99);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("halted%0d_if_gnt", k), ifGnt[0], 8'd0);
      checkOutput($sformatf("halted%0d_d_gnt", k), dGnt[0], 8'd0);
      checkOutput($sformatf("halted%0d_read", k), memRead[0], 8'd0);
      checkOutput($sformatf("halted%0d_write", k), memWrite[0], 8'd0);
      checkOutput($sformatf("halted%0d_flag", k), halted[0], 8'd1);
      @(negedge c);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset in the middle of a READ_LAT=3 read.
    resetAll();
    #1;
    checkOutput("rstrd_halted_clear", halted[0], 8'd0);
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkOutput("rstrd_if_gnt", ifGnt[2], 8'd1);
    @(negedge c);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b1;
    #1;
    checkOutput("rstrd_mem_read", memRead[2], 8'd1);
    checkOutput("rstrd_mem_addr", memAddr[2], 8'h05);
    @(negedge c);
    #1;
    checkOutput("rstrd_read_drop", memRead[2], 8'd0);
    checkOutput("rstrd_addr_drop", memAddr[2], 8'd0);
    checkOutput("rstrd_if_valid", ifValid[2], 8'd0);
    checkOutput("rstrd_if_rdata", ifRdata[2], 8'd0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge c);
      #1;
      checkOutput($sformatf("rstrd_quiet%0d_valid", k), ifValid[2], 8'd0);
      checkOutput($sformatf("rstrd_quiet%0d_read", k), memRead[2], 8'd0);
    end
    @(negedge c);
    applyStimulus(1'b1, 8'h07, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkOutput("rstrd_fresh_gnt", ifGnt[2], 8'd1);
    @(negedge c);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkOutput("rstrd_fresh_read1", memRead[2], 8'd1);
    checkOutput("rstrd_fresh_addr", memAddr[2], 8'h07);
    @(negedge c);
    #1;
    checkOutput("rstrd_fresh_read2", memRead[2], 8'd1);
    @(negedge c);
    #1;
    checkOutput("rstrd_fresh_read3", memRead[2], 8'd1);
    checkOutput("rstrd_fresh_early", ifValid[2], 8'd0);
    @(negedge c);
    #1;
    checkOutput("rstrd_fresh_valid", ifValid[2], 8'd1);
    checkOutput("rstrd_fresh_rdata", ifRdata[2], 8'h11);
    checkOutput("rstrd_fresh_rdoff", memRead[2], 8'd0);

    // Back-to-back fetches at 0 and 1 on the READ_LAT=2 instance.
    resetAll();
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkOutput("b2b_gnt0", ifGnt[1], 8'd1);
    @(negedge c);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkOutput("b2b_wait1", ifGnt[1], 8'd0);
    checkOutput("b2b_addr0", memAddr[1], 8'h00);
    checkOutput("b2b_read0", memRead[1], 8'd1);
    @(negedge c);
    #1;
    checkOutput("b2b_wait2", ifGnt[1], 8'd0);
    @(negedge c);
    #1;
    checkOutput("b2b_wait3", ifGnt[1], 8'd0);
    checkOutput("b2b_valid0", ifValid[1], 8'd1);
    checkOutput("b2b_rdata0", ifRdata[1], 8'h3C);
    @(negedge c);
    #1;
    checkOutput("b2b_gnt1", ifGnt[1], 8'd1);
    @(negedge c);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkOutput("b2b_addr1", memAddr[1], 8'h01);
    repeat (2) @(negedge c);
    #1;
    checkOutput("b2b_valid1", ifValid[1], 8'd1);
    checkOutput("b2b_rdata1", ifRdata[1], 8'hC7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
